user_seq_ctrl: RTL and testbench

USER_SEQ_CTRL -- requirements
Module: user_seq_ctrl

---
 rtl/genius_pkg.sv | 24 ++
 rtl/user_seq_ctrl_if.sv | 26 ++
 rtl/timeout_counter.sv | 29 ++
 rtl/user_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_user_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// Shared types and widths for the player-input sequencing logic.
package genius_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned MAX_ENTRIES = 16;
  localparam int unsigned DATA_W      = NIBBLE_W * MAX_ENTRIES;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned COUNT_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_PRESS,
    WAIT_RELEASE,
    COMMIT,
    FINISH
  } state_e;

  // A legal press has exactly one button asserted.
  function automatic logic is_onehot(input logic [NIBBLE_W-1:0] b);
    return (b != '0) && ((b & (b - NIBBLE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/user_seq_ctrl_if.sv
// Round control, button inputs and user-sequence register strobes.
interface user_seq_ctrl_if;
  import genius_pkg::*;

  logic                start;
  logic [LEN_W-1:0]    len;
  logic [NIBBLE_W-1:0] btn;
  logic                reg_R;
  logic                reg_E;
  logic [DATA_W-1:0]   reg_data;
  logic [COUNT_W-1:0]  count;
  logic                busy;
  logic                done;
  logic                timeout;

  modport master (
    output start, len, btn,
    input  reg_R, reg_E, reg_data, count, busy, done, timeout
  );

  modport slave (
    input  start, len, btn,
    output reg_R, reg_E, reg_data, count, busy, done, timeout
  );

endinterface

// File: rtl/timeout_counter.sv
// Saturating inactivity timer with synchronous clear and terminal-count flag.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 250000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned     CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == TC_VAL);

endmodule

// File: rtl/user_seq_ctrl.sv
// Collects one-hot button presses into the user-sequence register for one round,
// with a per-press inactivity timeout.
module user_seq_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned TIMEOUT = 250000000
) (
  input  logic            clk,
  input  logic            R,
  user_seq_ctrl_if.slave  bus
);

  state_e              state;
  logic [LEN_W-1:0]    len_q;
  logic                reg_r_q;
  logic                reg_e_q;
  logic [DATA_W-1:0]   data_q;
  logic [COUNT_W-1:0]  count_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_q;

  logic btn_onehot_c;
  logic btn_zero_c;
  logic timer_clear_c;
  logic timer_en_c;
  logic timer_tc_c;

  assign btn_onehot_c = is_onehot(bus.btn);
  assign btn_zero_c   = (bus.btn == '0);

  // The window starts at the CLEAR/COMMIT cycle, so done lands TIMEOUT cycles after it.
  assign timer_clear_c = (state == IDLE) || (state == WAIT_RELEASE);
  assign timer_en_c    = (state == CLEAR) || (state == COMMIT) ||
                         ((state == WAIT_PRESS) && !btn_onehot_c);

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (R),
    .clear  (timer_clear_c),
    .enable (timer_en_c),
    .tc_c   (timer_tc_c)
  );

  // Round sequencing; every output is a registered function of the transition taken.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state     <= IDLE;
      len_q     <= '0;
      reg_r_q   <= 1'b0;
      reg_e_q   <= 1'b0;
      data_q    <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      reg_r_q <= 1'b0;
      reg_e_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= CLEAR;
            len_q     <= bus.len;
            timeout_q <= 1'b0;
            reg_r_q   <= 1'b1;
            busy_q    <= 1'b1;
            data_q    <= '0;
            count_q   <= '0;
          end
        end
        CLEAR: begin
          state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (btn_onehot_c) begin
            data_q[{count_q[3:0], 2'b00} +: NIBBLE_W] <= bus.btn;
            state <= WAIT_RELEASE;
          end else if (timer_tc_c) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= FINISH;
          end
        end
        WAIT_RELEASE: begin
          if (btn_zero_c) begin
            reg_e_q <= 1'b1;
            count_q <= count_q + COUNT_W'(1);
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          if (count_q == COUNT_W'(len_q) + COUNT_W'(1)) begin
            done_q <= 1'b1;
            state  <= FINISH;
          end else begin
            state <= WAIT_PRESS;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_R    = reg_r_q;
  assign bus.reg_E    = reg_e_q;
  assign bus.reg_data = data_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_user_seq_ctrl.sv
// Self-checking bench for user_seq_ctrl: table vectors, corner sequences and
// randomized rounds scored against a packed-nibble reference model.
module tb_user_seq_ctrl;

  localparam int unsigned TMO = 100;

  logic clk = 1'b0;
  logic R   = 1'b1;

  user_seq_ctrl_if bus();

  user_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  len;
    logic [63:0] presses;
    logic [63:0] exp_data;
    logic [4:0]  exp_count;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int regr_cnt = 0, rege_cnt = 0, done_cnt = 0, overlap_cnt = 0, overflow_cnt = 0;
  int last_clear_cyc = 0, last_commit_cyc = 0, last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters and protocol invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.reg_R) begin regr_cnt++; last_clear_cyc = cyc; end
    if (bus.reg_E) begin rege_cnt++; last_commit_cyc = cyc; end
    if (bus.done)  begin done_cnt++; last_done_cyc = cyc; end
    if (bus.reg_R && bus.reg_E) overlap_cnt++;
    if (bus.count > 5'd16) overflow_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_round(input logic [3:0] l);
    bus.len   = l;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Optional idle gap, optional multi-hot glitch, then a held one-hot press and release.
  task automatic press(input logic [3:0] b, input int gap, input int glitch,
                       input int hold, output int lat);
    bus.btn = 4'b0000;
    tick(gap);
    if (glitch > 0) begin
      bus.btn = b | {b[2:0], b[3]};
      tick(glitch);
    end
    bus.btn = b;
    tick(hold);
    bus.btn = 4'b0000;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.reg_E) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round_end(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("round_end_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int r0, e0, d0, lat, n;
    r0 = regr_cnt; e0 = rege_cnt; d0 = done_cnt;
    n  = int'(v.len) + 1;
    start_round(v.len);
    for (int k = 0; k < n; k++) begin
      press(v.presses[4*k +: 4], int'($urandom_range(0, 2)), 0,
            int'($urandom_range(2, 3)), lat);
      check($sformatf("vec%0d_latency_%0d", idx, k), 64'(lat), 64'd2);
    end
    wait_round_end(int'(3 * TMO));
    check($sformatf("vec%0d_data", idx), bus.reg_data, v.exp_data);
    check($sformatf("vec%0d_count", idx), 64'(bus.count), 64'(v.exp_count));
    check($sformatf("vec%0d_reg_e_pulses", idx), 64'(rege_cnt - e0), 64'(v.exp_count));
    check($sformatf("vec%0d_done_pulses", idx), 64'(done_cnt - d0), 64'd1);
    check($sformatf("vec%0d_reg_r_pulses", idx), 64'(regr_cnt - r0), 64'd1);
    check($sformatf("vec%0d_flags", idx), 64'({bus.timeout, bus.busy}), 64'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    int          lat, r0, e0, d0, n, m;
    bit          to;
    logic [3:0]  l, b;
    logic [63:0] ed;

    vecs[0] = '{4'd2,  64'h0000_0000_0000_0841, 64'h0000_0000_0000_0841, 5'd3};
    vecs[1] = '{4'd15, 64'h2121_2121_2121_2121, 64'h2121_2121_2121_2121, 5'd16};
    vecs[2] = '{4'd0,  64'h0000_0000_0000_0008, 64'h0000_0000_0000_0008, 5'd1};
    vecs[3] = '{4'd3,  64'h0000_0000_0000_4812, 64'h0000_0000_0000_4812, 5'd4};
    vecs[4] = '{4'd7,  64'h0000_0000_1248_8421, 64'h0000_0000_1248_8421, 5'd8};

    bus.start = 1'b0;
    bus.len   = 4'd0;
    bus.btn   = 4'd0;

    // Reset state, during and after reset.
    tick(2);
    check("reset_flags_during", 64'({bus.reg_R, bus.reg_E, bus.busy, bus.done, bus.timeout, bus.count}), 64'd0);
    check("reset_data_during", bus.reg_data, 64'd0);
    R = 1'b0;
    tick(2);
    check("reset_flags_after", 64'({bus.reg_R, bus.reg_E, bus.busy, bus.done, bus.timeout, bus.count}), 64'd0);

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
      if (vecs[i].exp_count == 5'd16) begin
        e0 = rege_cnt;
        bus.btn = 4'b0001;
        tick(3);
        bus.btn = 4'b0000;
        tick(4);
        check("full_no_extra_reg_e", 64'(rege_cnt - e0), 64'd0);
        check("full_count_hold", 64'(bus.count), 64'd16);
        check("full_data_hold", bus.reg_data, 64'h2121_2121_2121_2121);
      end
    end

    // One press then silence: done arrives TMO cycles after the COMMIT cycle.
    d0 = done_cnt;
    start_round(4'd3);
    press(4'b0001, 0, 0, 2, lat);
    wait_round_end(int'(3 * TMO));
    check("tmo_commit_to_done", 64'(last_done_cyc - last_commit_cyc), 64'(TMO));
    check("tmo_flag", 64'(bus.timeout), 64'd1);
    check("tmo_count", 64'(bus.count), 64'd1);
    check("tmo_data", bus.reg_data, 64'h1);
    check("tmo_done_pulses", 64'(done_cnt - d0), 64'd1);

    // No presses at all: window measured from the CLEAR cycle.
    start_round(4'd0);
    wait_round_end(int'(3 * TMO));
    check("tmo0_clear_to_done", 64'(last_done_cyc - last_clear_cyc), 64'(TMO));
    check("tmo0_count", 64'(bus.count), 64'd0);
    check("tmo0_flag", 64'(bus.timeout), 64'd1);

    // CLEAR cycle wipes the previous round and the sticky timeout.
    r0 = regr_cnt;
    start_round(4'd0);
    @(negedge clk);
    check("clear_outputs", 64'({bus.reg_R, bus.reg_E, bus.busy, bus.timeout, bus.count}), 64'b1_0_1_0_00000);
    check("clear_data", bus.reg_data, 64'd0);
    press(4'b0100, 0, 0, 2, lat);
    wait_round_end(int'(3 * TMO));
    check("clear_round_data", bus.reg_data, 64'h4);
    check("clear_reg_r_pulses", 64'(regr_cnt - r0), 64'd1);

    // Multi-hot held for 50 cycles is not captured.
    e0 = rege_cnt;
    start_round(4'd0);
    bus.btn = 4'b0011;
    tick(50);
    check("multihot_no_reg_e", 64'(rege_cnt - e0), 64'd0);
    check("multihot_state", 64'({bus.busy, bus.count}), 64'b1_00000);
    press(4'b0010, 0, 0, 2, lat);
    check("multihot_latency", 64'(lat), 64'd2);
    wait_round_end(int'(3 * TMO));
    check("multihot_data", bus.reg_data, 64'h2);
    check("multihot_count", 64'(bus.count), 64'd1);
    check("multihot_timeout", 64'(bus.timeout), 64'd0);

    // Reset while waiting for release aborts without done.
    d0 = done_cnt;
    start_round(4'd3);
    bus.btn = 4'b0100;
    tick(3);
    check("abort_captured", bus.reg_data, 64'h4);
    R = 1'b1;
    #1;
    check("abort_flags", 64'({bus.reg_R, bus.reg_E, bus.busy, bus.done, bus.timeout, bus.count}), 64'd0);
    check("abort_data", bus.reg_data, 64'd0);
    tick(2);
    bus.btn = 4'b0000;
    R = 1'b0;
    tick(5);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    r0 = regr_cnt;
    start_round(4'd0);
    @(negedge clk);
    check("abort_restart_clear", 64'({bus.reg_R, bus.count}), 64'b1_00000);
    press(4'b0001, 0, 0, 2, lat);
    wait_round_end(int'(3 * TMO));
    check("abort_restart_data", bus.reg_data, 64'h1);
    check("abort_restart_reg_r", 64'(regr_cnt - r0), 64'd1);

    // Start while busy is ignored; latched length still governs.
    d0 = done_cnt; r0 = regr_cnt;
    start_round(4'd1);
    press(4'b0001, 0, 0, 2, lat);
    bus.len   = 4'd0;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
    check("busy_start_no_done", 64'(done_cnt - d0), 64'd0);
    check("busy_start_busy", 64'(bus.busy), 64'd1);
    check("busy_start_no_clear", 64'(regr_cnt - r0), 64'd1);
    press(4'b0010, 0, 0, 2, lat);
    wait_round_end(int'(3 * TMO));
    check("busy_start_count", 64'(bus.count), 64'd2);
    check("busy_start_data", bus.reg_data, 64'h21);

    // Randomized rounds, some deliberately abandoned to time out.
    for (int r = 0; r < 24; r++) begin
      l  = 4'($urandom_range(0, 7));
      n  = int'(l) + 1;
      m  = n;
      to = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        m  = int'($urandom_range(0, n - 1));
        to = 1'b1;
      end
      ed = 64'd0;
      e0 = rege_cnt; d0 = done_cnt;
      start_round(l);
      for (int k = 0; k < m; k++) begin
        b = 4'(1 << $urandom_range(0, 3));
        press(b, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(2, 4)), lat);
        check($sformatf("rnd%0d_latency_%0d", r, k), 64'(lat), 64'd2);
        ed = ed | (64'(b) << (4 * k));
      end
      wait_round_end(int'(3 * TMO));
      check($sformatf("rnd%0d_data", r), bus.reg_data, ed);
      check($sformatf("rnd%0d_count", r), 64'(bus.count), 64'(m));
      check($sformatf("rnd%0d_reg_e", r), 64'(rege_cnt - e0), 64'(m));
      check($sformatf("rnd%0d_done", r), 64'(done_cnt - d0), 64'd1);
      check($sformatf("rnd%0d_timeout", r), 64'(bus.timeout), 64'(to));
      check($sformatf("rnd%0d_busy", r), 64'(bus.busy), 64'd0);
    end

    check("strobe_overlap", 64'(overlap_cnt), 64'd0);
    check("count_overflow", 64'(overflow_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
